wbr_param_wrapper: RTL and testbench
====================================

WBR_PARAM_WRAPPER -- requirements
Module: wbr_param_wrapper

Interface
REQ-001 Parameter N_IN, default 4, number of core-input boundary cells (>=1).
REQ-002 Parameter N_OUT, default 4, number of core-output boundary cells (>=1).
REQ-003 Parameter WIR_W, default 3, wrapper instruction register width (>=3).
REQ-004 Parameter SAFE_VAL, default all-zero N_OUT bits, value driven on pin_out under WS_SAFE.
REQ-005 WRCK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  reset; asynchronous and active-high.
REQ-007 SelectWIR  in  1  1 = operation targets the WIR; 0 = operation targets the selected data register.
REQ-008 CaptureWR / ShiftWR / UpdateWR  in  1 each  capture, shift and update strobes.
REQ-009 WSI  in  1  serial data in.  WSO  out  1  serial data out.
REQ-010 pin_in  in  N_IN  chip-side inputs.  core_in  out  N_IN  to core.
REQ-011 core_out  in  N_OUT  from core.  pin_out  out  N_OUT  chip-side outputs.
REQ-012 cur_instr  out  WIR_W  active instruction.  instr_illegal  out  1  active opcode is undefined.

Function
REQ-013 Opcodes SHALL be: 0 WS_BYPASS, 1 WS_EXTEST, 2 WS_INTEST, 3 WS_PRELOAD, 4 WS_SAFE. Any other opcode SHALL behave as WS_BYPASS with instr_illegal=1.
REQ-014 WIR shift stage: on SelectWIR&ShiftWR, wir_sh <= {WSI, wir_sh[WIR_W-1:1]}. On SelectWIR&CaptureWR, wir_sh <= cur_instr.
REQ-015 On SelectWIR&UpdateWR, cur_instr <= wir_sh. The new instruction SHALL govern muxing and register selection from the cycle after that edge.
REQ-016 WBY is 1 bit and is selected for WS_BYPASS, WS_SAFE and illegal opcodes. On !SelectWIR with WBY selected: CaptureWR loads 0; ShiftWR loads WSI.
REQ-017 WBR shift chain has N_IN+N_OUT cells. Cells 0..N_IN-1 are input cells; cells N_IN..N_IN+N_OUT-1 are output cells. It is selected for WS_EXTEST, WS_INTEST and WS_PRELOAD.
REQ-018 WBR shift, when selected and !SelectWIR&ShiftWR: WSI enters the top cell, every cell k takes cell k+1, and cell 0 feeds WSO. One bit moves per WRCK.
REQ-019 WBR capture, when !SelectWIR&CaptureWR:
- WS_EXTEST: input cells load pin_in; output cells hold.
- WS_INTEST: output cells load core_out; input cells hold.
- WS_PRELOAD: no cell changes.
REQ-020 WBR update, when selected and !SelectWIR&UpdateWR: the parallel update stage loads the full shift chain value as it stood before that edge.
REQ-021 Strobe priority on the same edge: CaptureWR over ShiftWR. UpdateWR acts concurrently with either and always uses the pre-edge shift value.
REQ-022 Outputs (combinational from registers):
- core_in = upd_in under WS_INTEST, otherwise pin_in.
- pin_out = upd_out under WS_EXTEST, SAFE_VAL under WS_SAFE, otherwise core_out.
REQ-023 WSO = wir_sh[0] when SelectWIR=1, otherwise bit 0 of the selected data register. It is purely combinational from registers, with no path from WSI.
REQ-024 Strobes addressed to the non-selected register SHALL NOT alter it. The WBR shift chain and update stage SHALL retain their contents across instruction changes.

Reset
REQ-025 While RESET=1: wir_sh=0, cur_instr=0 (WS_BYPASS), WBY=0, and all WBR shift and update cells=0.
REQ-026 While RESET=1: core_in=pin_in, pin_out=core_out, instr_illegal=0, and WSO=0.
REQ-027 Reset asserted mid-shift or mid-update SHALL discard the partial operation. The first strobe after deassertion SHALL act on reset values.

Verification
REQ-028 Defaults, reset, then 3 SelectWIR shifts of WSI=1,0,0 and UpdateWR -> cur_instr=1 (EXTEST), instr_illegal=0.
REQ-029 EXTEST, pin_in=4'hA, CaptureWR, then 8 ShiftWR -> WSO emits 0,1,0,1,0,0,0,0 (cell 0 first).
REQ-030 PRELOAD, shift in 8'hC3, UpdateWR, load EXTEST -> pin_out=4'hC and stays there regardless of core_out. Switching to INTEST -> core_in=4'h3 and pin_out=core_out.
REQ-031 Load opcode 7 -> instr_illegal=1 and WSO follows WSI delayed by one WRCK through WBY. Load WS_SAFE -> pin_out=SAFE_VAL and instr_illegal=0.
REQ-032 CaptureWR and ShiftWR on the same edge -> capture result only. Assert RESET mid-shift of 4 bits -> all registers 0 immediately, WSO=0.

Source files
------------

// File: rtl/wbr_param_wrapper.sv
// Parameterised core wrapper: instruction register (WIR), 1-bit bypass (WBY)
// and a boundary register (WBR) with capture/shift/update stages. Everything
// is clocked by WRCK and cleared asynchronously by RESET.
//
// Strobe semantics: on a rising WRCK edge a strobe acts only on the register
// addressed by SelectWIR (WIR when 1, the selected data register when 0).
// CaptureWR wins over ShiftWR on the same edge; UpdateWR acts alongside either
// and always transfers the shift-stage value as it stood before the edge.
module wbr_param_wrapper #(
  parameter int                N_IN     = 4,
  parameter int                N_OUT    = 4,
  parameter int                WIR_W    = 3,
  parameter logic [N_OUT-1:0]  SAFE_VAL = '0
) (
  input  logic               WRCK,
  input  logic               RESET,
  input  logic               SelectWIR,
  input  logic               CaptureWR,
  input  logic               ShiftWR,
  input  logic               UpdateWR,
  input  logic               WSI,
  output logic               WSO,
  input  logic [N_IN-1:0]    pin_in,
  output logic [N_IN-1:0]    core_in,
  input  logic [N_OUT-1:0]   core_out,
  output logic [N_OUT-1:0]   pin_out,
  output logic [WIR_W-1:0]   cur_instr,
  output logic               instr_illegal
);

  localparam int N_WBR = N_IN + N_OUT;

  localparam logic [WIR_W-1:0] WS_BYPASS  = WIR_W'(0);
  localparam logic [WIR_W-1:0] WS_EXTEST  = WIR_W'(1);
  localparam logic [WIR_W-1:0] WS_INTEST  = WIR_W'(2);
  localparam logic [WIR_W-1:0] WS_PRELOAD = WIR_W'(3);
  localparam logic [WIR_W-1:0] WS_SAFE    = WIR_W'(4);

  logic [WIR_W-1:0] wir_sh;
  logic             wby;
  logic [N_WBR-1:0] wbr_sh;
  logic [N_WBR-1:0] wbr_upd;
  logic [N_WBR-1:0] wbr_cap_val;

  logic is_bypass, is_extest, is_intest, is_preload, is_safe, is_legal;
  logic wbr_sel;

  logic wir_cap_en, wir_shift_en, wir_upd_en;
  logic dr_cap_en, dr_shift_en, dr_upd_en;

  // Decode the active instruction; undefined opcodes fall back to bypass.
  always_comb begin
    is_bypass  = (cur_instr == WS_BYPASS);
    is_extest  = (cur_instr == WS_EXTEST);
    is_intest  = (cur_instr == WS_INTEST);
    is_preload = (cur_instr == WS_PRELOAD);
    is_safe    = (cur_instr == WS_SAFE);
    is_legal   = is_bypass | is_extest | is_intest | is_preload | is_safe;
    wbr_sel    = is_extest | is_intest | is_preload;
  end

  // Qualify the raw strobes by target register; capture masks shift.
  always_comb begin
    wir_cap_en   = SelectWIR & CaptureWR;
    wir_shift_en = SelectWIR & ShiftWR & ~CaptureWR;
    wir_upd_en   = SelectWIR & UpdateWR;
    dr_cap_en    = ~SelectWIR & CaptureWR;
    dr_shift_en  = ~SelectWIR & ShiftWR & ~CaptureWR;
    dr_upd_en    = ~SelectWIR & UpdateWR;
  end

  // WIR shift stage: capture reloads the active opcode, shift moves toward bit 0.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      wir_sh <= '0;
    end else if (wir_cap_en) begin
      wir_sh <= cur_instr;
    end else if (wir_shift_en) begin
      wir_sh <= {WSI, wir_sh[WIR_W-1:1]};
    end
  end

  // WIR update stage: the new opcode takes effect from the next cycle.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      cur_instr <= WS_BYPASS;
    end else if (wir_upd_en) begin
      cur_instr <= wir_sh;
    end
  end

  // Bypass bit: used by bypass, safe and any undefined opcode.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      wby <= 1'b0;
    end else if (!wbr_sel) begin
      if (dr_cap_en) begin
        wby <= 1'b0;
      end else if (dr_shift_en) begin
        wby <= WSI;
      end
    end
  end

  // Capture value per instruction: EXTEST samples pins into the input cells,
  // INTEST samples the core into the output cells, PRELOAD leaves all cells.
  always_comb begin
    wbr_cap_val = wbr_sh;
    if (is_extest) begin
      wbr_cap_val[N_IN-1:0] = pin_in;
    end
    if (is_intest) begin
      wbr_cap_val[N_WBR-1:N_IN] = core_out;
    end
  end

  // WBR shift chain: WSI enters the top cell, cell 0 drives WSO.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      wbr_sh <= '0;
    end else if (wbr_sel) begin
      if (dr_cap_en) begin
        wbr_sh <= wbr_cap_val;
      end else if (dr_shift_en) begin
        wbr_sh <= {WSI, wbr_sh[N_WBR-1:1]};
      end
    end
  end

  // WBR update stage: parallel copy of the pre-edge shift chain.
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      wbr_upd <= '0;
    end else if (wbr_sel && dr_upd_en) begin
      wbr_upd <= wbr_sh;
    end
  end

  // Functional muxing between pins, core and the update stage.
  always_comb begin
    core_in = pin_in;
    pin_out = core_out;
    if (is_intest) begin
      core_in = wbr_upd[N_IN-1:0];
    end
    if (is_extest) begin
      pin_out = wbr_upd[N_WBR-1:N_IN];
    end else if (is_safe) begin
      pin_out = SAFE_VAL;
    end
  end

  // Serial output: purely from register state, never from WSI directly.
  always_comb begin
    WSO = 1'b0;
    if (SelectWIR) begin
      WSO = wir_sh[0];
    end else if (wbr_sel) begin
      WSO = wbr_sh[0];
    end else begin
      WSO = wby;
    end
  end

  assign instr_illegal = ~is_legal;

endmodule

// File: tb/tb_wbr_param_wrapper.sv
// Directed bench for wbr_param_wrapper with default parameters.
module tb_wbr_param_wrapper;

  logic       WRCK;
  logic       RESET;
  logic       SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI;
  logic       WSO;
  logic [3:0] pin_in, core_in, core_out, pin_out;
  logic [2:0] cur_instr;
  logic       instr_illegal;

  int n_pass  = 0;
  int n_total = 0;

  wbr_param_wrapper dut (
    .WRCK(WRCK), .RESET(RESET), .SelectWIR(SelectWIR), .CaptureWR(CaptureWR),
    .ShiftWR(ShiftWR), .UpdateWR(UpdateWR), .WSI(WSI), .WSO(WSO),
    .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out),
    .cur_instr(cur_instr), .instr_illegal(instr_illegal)
  );

  // Clock and watchdog
  initial WRCK = 1'b0;
  always #5 WRCK = ~WRCK;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       sel, cap, sh, upd, wsi;
    logic [3:0] pin, cout;
    logic       wso;
    logic [3:0] cin_e, pout_e;
    logic [2:0] instr_e;
    logic       ill_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sel, cap, sh, upd, wsi,
                              input logic [3:0] pin, cout, input logic wso,
                              input logic [3:0] cin, pout,
                              input logic [2:0] instr, input logic ill);
    vec_t v;
    v.sel = sel; v.cap = cap; v.sh = sh; v.upd = upd; v.wsi = wsi;
    v.pin = pin; v.cout = cout; v.wso = wso;
    v.cin_e = cin; v.pout_e = pout; v.instr_e = instr; v.ill_e = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One WRCK edge with the given strobes; strobes drop 1 time unit after it.
  task automatic step(input logic sel, cap, sh, upd, wsi);
    SelectWIR = sel; CaptureWR = cap; ShiftWR = sh; UpdateWR = upd; WSI = wsi;
    @(posedge WRCK);
    #1;
    CaptureWR = 1'b0; ShiftWR = 1'b0; UpdateWR = 1'b0;
  endtask

  task automatic load_instr(input logic [2:0] op);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, op[i]);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] wsi_a, wso_a, wsi_b, wso_b;
    logic [4:0] bits;
    vec_t v;

    // Table: WIR load of EXTEST, EXTEST capture/shift, PRELOAD, INTEST.
    wsi_a = 8'hC3; wso_a = 8'h85; wsi_b = 8'h96; wso_b = 8'h61;
    tbl.push_back(mk(1,0,1,0,1, 4'h3,4'h6, 0, 4'h3,4'h6, 3'd0,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h3,4'h6, 0, 4'h3,4'h6, 3'd0,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h3,4'h6, 1, 4'h3,4'h6, 3'd0,0));
    tbl.push_back(mk(1,0,0,1,0, 4'h3,4'h6, 1, 4'h3,4'h0, 3'd1,0));
    tbl.push_back(mk(0,1,0,0,0, 4'hA,4'h5, 0, 4'hA,4'h0, 3'd1,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,1,0,wsi_a[i], 4'hA,4'h5, wso_a[i], 4'hA,4'h0, 3'd1,0));
    tbl.push_back(mk(0,0,0,1,0, 4'hA,4'h5, 1, 4'hA,4'hC, 3'd1,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hA,4'hF, 1, 4'hA,4'hC, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'hA,4'hF, 0, 4'hA,4'hC, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'hA,4'hF, 0, 4'hA,4'hC, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'hA,4'hF, 1, 4'hA,4'hC, 3'd1,0));
    tbl.push_back(mk(1,0,0,1,0, 4'hA,4'hF, 1, 4'hA,4'hF, 3'd3,0));
    tbl.push_back(mk(0,1,0,0,0, 4'h5,4'hF, 1, 4'h5,4'hF, 3'd3,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,1,0,wsi_b[i], 4'h5,4'hF, wso_b[i], 4'h5,4'hF, 3'd3,0));
    tbl.push_back(mk(0,0,0,1,0, 4'h5,4'hF, 0, 4'h5,4'hF, 3'd3,0));
    tbl.push_back(mk(1,0,1,0,1, 4'h5,4'hF, 1, 4'h5,4'hF, 3'd3,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h5,4'hF, 0, 4'h5,4'hF, 3'd3,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h5,4'hF, 1, 4'h5,4'hF, 3'd3,0));
    tbl.push_back(mk(1,0,0,1,0, 4'h5,4'hF, 1, 4'h5,4'h9, 3'd1,0));
    tbl.push_back(mk(0,0,0,0,0, 4'h5,4'h0, 0, 4'h5,4'h9, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h5,4'h0, 0, 4'h5,4'h9, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,1, 4'h5,4'h0, 0, 4'h5,4'h9, 3'd1,0));
    tbl.push_back(mk(1,0,1,0,0, 4'h5,4'h0, 0, 4'h5,4'h9, 3'd1,0));
    tbl.push_back(mk(1,0,0,1,0, 4'h5,4'h7, 0, 4'h6,4'h7, 3'd2,0));
    tbl.push_back(mk(0,1,0,0,0, 4'h5,4'h7, 0, 4'h6,4'h7, 3'd2,0));
    tbl.push_back(mk(0,0,1,0,0, 4'h5,4'h7, 1, 4'h6,4'h7, 3'd2,0));

    // Reset phase
    RESET = 1'b1;
    SelectWIR = 1'b0; CaptureWR = 1'b0; ShiftWR = 1'b0; UpdateWR = 1'b0; WSI = 1'b1;
    pin_in = 4'h5; core_out = 4'h9;
    repeat (2) @(posedge WRCK);
    #1;
    chk("rst_cur_instr", 32'(cur_instr), 32'd0);
    chk("rst_illegal", 32'(instr_illegal), 32'd0);
    chk("rst_core_in", 32'(core_in), 32'h5);
    chk("rst_pin_out", 32'(pin_out), 32'h9);
    chk("rst_wso_dr", 32'(WSO), 32'd0);
    SelectWIR = 1'b1;
    #1;
    chk("rst_wso_wir", 32'(WSO), 32'd0);
    @(posedge WRCK);
    #1;
    RESET = 1'b0;

    // Table-driven section
    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      pin_in = v.pin; core_out = v.cout;
      step(v.sel, v.cap, v.sh, v.upd, v.wsi);
      chk($sformatf("row%0d_wso", r), 32'(WSO), 32'(v.wso));
      chk($sformatf("row%0d_core_in", r), 32'(core_in), 32'(v.cin_e));
      chk($sformatf("row%0d_pin_out", r), 32'(pin_out), 32'(v.pout_e));
      chk($sformatf("row%0d_instr", r), 32'(cur_instr), 32'(v.instr_e));
      chk($sformatf("row%0d_illegal", r), 32'(instr_illegal), 32'(v.ill_e));
    end

    // Illegal opcode 7 behaves as bypass through WBY
    pin_in = 4'h3; core_out = 4'hB;
    load_instr(3'd7);
    chk("ill_instr", 32'(cur_instr), 32'd7);
    chk("ill_flag", 32'(instr_illegal), 32'd1);
    chk("ill_core_in", 32'(core_in), 32'h3);
    chk("ill_pin_out", 32'(pin_out), 32'hB);
    bits = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, bits[i]);
      chk($sformatf("wby_delay%0d", i), 32'(WSO), 32'(bits[i]));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wby_shift1", 32'(WSO), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("wby_capture0", 32'(WSO), 32'd0);

    // SAFE drives SAFE_VAL (zero) on the pins
    core_out = 4'hF;
    load_instr(3'd4);
    chk("safe_instr", 32'(cur_instr), 32'd4);
    chk("safe_illegal", 32'(instr_illegal), 32'd0);
    chk("safe_pin_out", 32'(pin_out), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("safe_wby", 32'(WSO), 32'd1);

    // Capture and shift on the same edge: capture only; update stage retained
    pin_in = 4'hA; core_out = 4'h6;
    load_instr(3'd1);
    chk("ext_pin_out_kept", 32'(pin_out), 32'h9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("capsh_wso", 32'(WSO), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("capsh_next", 32'(WSO), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("capsh_next2", 32'(WSO), 32'd0);

    // Reset asserted mid-shift clears everything at once
    SelectWIR = 1'b0; ShiftWR = 1'b1; WSI = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_rst_instr", 32'(cur_instr), 32'd0);
    chk("mid_rst_illegal", 32'(instr_illegal), 32'd0);
    chk("mid_rst_wso", 32'(WSO), 32'd0);
    chk("mid_rst_core_in", 32'(core_in), 32'hA);
    chk("mid_rst_pin_out", 32'(pin_out), 32'h6);
    SelectWIR = 1'b1;
    #1;
    chk("mid_rst_wso_wir", 32'(WSO), 32'd0);
    @(posedge WRCK);
    #1;
    ShiftWR = 1'b0;
    RESET = 1'b0;
    core_out = 4'hF;
    load_instr(3'd1);
    chk("post_rst_instr", 32'(cur_instr), 32'd1);
    chk("post_rst_pin_out", 32'(pin_out), 32'h0);
    SelectWIR = 1'b0;
    #1;
    chk("post_rst_wbr0", 32'(WSO), 32'd0);

    // Update concurrent with shift uses the pre-edge chain
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_upd_pin_out", 32'(pin_out), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("shupd_pin_out", 32'(pin_out), 32'hE);
    chk("shupd_wso", 32'(WSO), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("upd_pin_out", 32'(pin_out), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
